// File: rtl/dft_uart_tx_scheduler.sv
// Round-robin merge of PC-trace and V0-result words into a tagged FIFO, drained by a
// byte-serialising TX FSM that frames each word as SYNC, tag, data (MSB first) to the DFT UART.
module dft_uart_tx_scheduler #(
  parameter int         BIT_WIDTH   = 32,
  parameter int         FIFO_DEPTH  = 8,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         ACK_TIMEOUT = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pc_valid,
  input  logic [BIT_WIDTH-1:0]        pc_data,
  output logic                        pc_ready,
  input  logic                        v0_valid,
  input  logic [BIT_WIDTH-1:0]        v0_data,
  output logic                        v0_ready,
  input  logic                        uart_busy,
  output logic                        uart_wr_i,
  output logic [7:0]                  uart_dat_i,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [15:0]                 tx_frames
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;
  localparam int NBYTES = 2 + BIT_WIDTH / 8;
  localparam int BW     = $clog2(NBYTES);
  localparam int FW     = NBYTES * 8;
  localparam int TW     = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_ACK, S_DONE} state_t;

  // FIFO entry is {tag, data}; tag 0 = PC, 1 = V0
  logic [BIT_WIDTH:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic                 r_rr_v0;

  state_t               r_state, w_state_next;
  logic [BW-1:0]        r_byte_idx, w_byte_idx_next;
  logic [TW-1:0]        r_timer, w_timer_next;
  logic                 r_wr, w_wr_next;
  logic [7:0]           r_dat, w_dat_next;
  logic [15:0]          r_frames, w_frames_next;
  logic [FW-1:0]        r_frame;

  logic                 w_full, w_empty, w_push, w_push_pc, w_push_v0, w_pop;
  logic                 w_shift, w_byte_done;
  logic [BIT_WIDTH:0]   w_push_word;

  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_push_pc = pc_valid & pc_ready;
  assign w_push_v0 = v0_valid & v0_ready;
  assign w_push    = w_push_pc | w_push_v0;
  assign w_push_word = w_push_v0 ? {1'b1, v0_data} : {1'b0, pc_data};
  assign w_pop     = (r_state == S_LOAD);

  // Exactly one ready while not full, so at most one push per cycle
  always_comb begin
    pc_ready = 1'b0;
    v0_ready = 1'b0;
    if (!w_full) begin
      if (r_rr_v0) begin
        if (v0_valid) v0_ready = 1'b1;
        else          pc_ready = 1'b1;
      end else begin
        if (pc_valid) pc_ready = 1'b1;
        else          v0_ready = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rr_v0  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_rr_v0  <= w_push_pc;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Frame register doubles as the registered RAM read; shifting left exposes the next byte
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD)
      r_frame <= {SYNC_BYTE, 7'd0, r_mem[r_rd_ptr]};
    else if (w_shift)
      r_frame <= {r_frame[FW-9:0], 8'h00};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_byte_idx <= '0;
      r_timer    <= '0;
      r_wr       <= 1'b0;
      r_dat      <= 8'h00;
      r_frames   <= 16'h0000;
    end else begin
      r_state    <= w_state_next;
      r_byte_idx <= w_byte_idx_next;
      r_timer    <= w_timer_next;
      r_wr       <= w_wr_next;
      r_dat      <= w_dat_next;
      r_frames   <= w_frames_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_byte_idx_next = r_byte_idx;
    w_timer_next    = r_timer;
    w_wr_next       = 1'b0;
    w_dat_next      = r_dat;
    w_frames_next   = r_frames;
    w_shift         = 1'b0;
    w_byte_done     = 1'b0;
    case (r_state)
      S_IDLE: if (!w_empty) w_state_next = S_LOAD;
      S_LOAD: begin
        w_byte_idx_next = '0;
        w_state_next    = S_SEND;
      end
      S_SEND: if (!uart_busy) begin
        w_wr_next    = 1'b1;
        w_dat_next   = r_frame[FW-1 -: 8];
        w_timer_next = '0;
        w_state_next = S_ACK;
      end
      // A UART that never raises busy is treated as done after the timeout
      S_ACK: begin
        if (uart_busy)                          w_state_next = S_DONE;
        else if (r_timer == TW'(ACK_TIMEOUT-1)) w_byte_done  = 1'b1;
        else                                    w_timer_next = r_timer + TW'(1);
      end
      S_DONE: if (!uart_busy) w_byte_done = 1'b1;
      default: w_state_next = S_IDLE;
    endcase
    if (w_byte_done) begin
      if (r_byte_idx != BW'(NBYTES-1)) begin
        w_byte_idx_next = r_byte_idx + BW'(1);
        w_shift         = 1'b1;
        w_state_next    = S_SEND;
      end else begin
        w_frames_next = r_frames + 16'd1;
        w_state_next  = w_empty ? S_IDLE : S_LOAD;
      end
    end
  end

  assign uart_wr_i  = r_wr;
  assign uart_dat_i = r_dat;
  assign fifo_count = r_count;
  assign tx_frames  = r_frames;

endmodule

// File: tb/tb_dft_uart_tx_scheduler.sv
// Directed bench for dft_uart_tx_scheduler: sources and UART busy driven after each rising edge,
// strobes/grants logged on the falling edge and compared against hand-computed frames.
module tb_dft_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_valid = 1'b0, v0_valid = 1'b0, uart_busy = 1'b0;
  logic [31:0] pc_data = '0, v0_data = '0;
  logic        pc_ready, v0_ready, uart_wr_i;
  logic [7:0]  uart_dat_i;
  logic [3:0]  fifo_count;
  logic [15:0] tx_frames;

  always #5 clk = ~clk;

  dft_uart_tx_scheduler dut (
    .clk(clk), .rst(rst),
    .pc_valid(pc_valid), .pc_data(pc_data), .pc_ready(pc_ready),
    .v0_valid(v0_valid), .v0_data(v0_data), .v0_ready(v0_ready),
    .uart_busy(uart_busy), .uart_wr_i(uart_wr_i), .uart_dat_i(uart_dat_i),
    .fifo_count(fifo_count), .tx_frames(tx_frames)
  );

  int          checks = 0, errors = 0, cyc = 0;
  int          last_grant_cyc = 0, busy_mode = 0, busy_cnt = 0;
  logic [7:0]  byte_q[$];
  int          stamp_q[$];
  int          grant_q[$];
  logic [31:0] pc_q[$], v0_q[$];
  logic        pc_acc = 1'b0, v0_acc = 1'b0, strobe_seen = 1'b0, prev_wr = 1'b0;

  function automatic logic [7:0] fb(input logic tag, input logic [31:0] d, input int b);
    if (b == 0) return 8'hA5;
    if (b == 1) return {7'd0, tag};
    return d[31-8*(b-2) -: 8];
  endfunction

  // Falling-edge observer: grants, strobes and UART protocol rules
  always @(negedge clk) begin
    cyc++;
    pc_acc = pc_valid && pc_ready;
    v0_acc = v0_valid && v0_ready;
    if (pc_acc) begin grant_q.push_back(0); last_grant_cyc = cyc; end
    if (v0_acc) begin grant_q.push_back(1); last_grant_cyc = cyc; end
    if (pc_acc && v0_acc) begin
      errors++;
      $display("FAIL dual_grant: got both readys accepted, required at most one");
    end
    strobe_seen = uart_wr_i;
    if (uart_wr_i) begin
      byte_q.push_back(uart_dat_i);
      stamp_q.push_back(cyc);
      checks++;
      if (uart_busy !== 1'b0) begin
        errors++;
        $display("FAIL wr_while_busy: got busy=%b at strobe, required 0", uart_busy);
      end
      checks++;
      if (prev_wr !== 1'b0) begin
        errors++;
        $display("FAIL wr_back_to_back: got strobe on consecutive cycles, required gap");
      end
    end
    prev_wr = uart_wr_i;
  end

  task automatic step();
    @(posedge clk); #1;
    if (pc_acc) void'(pc_q.pop_front());
    if (v0_acc) void'(v0_q.pop_front());
    pc_valid = (pc_q.size() != 0);
    pc_data  = pc_valid ? pc_q[0] : 32'h0;
    v0_valid = (v0_q.size() != 0);
    v0_data  = v0_valid ? v0_q[0] : 32'h0;
    case (busy_mode)
      0: begin uart_busy = 1'b0; busy_cnt = 0; end
      1: uart_busy = 1'b1;
      default: begin
        if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) uart_busy = 1'b0;
        end else if (strobe_seen) begin
          uart_busy = 1'b1;
          busy_cnt  = 10;
        end
      end
    endcase
  endtask

  task automatic clear_logs();
    byte_q.delete(); stamp_q.delete(); grant_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1; pc_valid = 1'b1; v0_valid = 1'b1;
    #1;
    checks++;
    if (pc_ready !== 1'b1 || v0_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_rr: got pc_ready=%b v0_ready=%b, required 1/0", pc_ready, v0_ready);
    end
    pc_valid = 1'b0; v0_valid = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++;
    if (uart_wr_i !== 1'b0 || uart_dat_i !== 8'h00) begin
      errors++;
      $display("FAIL reset_uart: got wr=%b dat=%02h, required 0/00", uart_wr_i, uart_dat_i);
    end
    checks++;
    if (fifo_count !== 4'd0 || tx_frames !== 16'd0) begin
      errors++;
      $display("FAIL reset_counts: got count=%0d frames=%0d, required 0/0", fifo_count, tx_frames);
    end
    clear_logs();
  endtask

  task automatic test_single();
    logic [7:0] exp_b [6];
    exp_b[0] = 8'hA5; exp_b[1] = 8'h00; exp_b[2] = 8'h12;
    exp_b[3] = 8'h34; exp_b[4] = 8'h56; exp_b[5] = 8'h78;
    busy_mode = 0;
    clear_logs();
    pc_q.push_back(32'h1234_5678);
    for (int i = 0; i < 200 && byte_q.size() < 6; i++) step();
    repeat (10) step();
    checks++;
    if (byte_q.size() != 6) begin
      errors++;
      $display("FAIL single_count: got %0d bytes, required 6", byte_q.size());
    end else begin
      checks++;
      if (stamp_q[0] - last_grant_cyc != 4) begin
        errors++;
        $display("FAIL single_latency: got %0d cycles, required 4", stamp_q[0] - last_grant_cyc);
      end
      for (int b = 0; b < 6; b++) begin
        checks++;
        if (byte_q[b] !== exp_b[b]) begin
          errors++;
          $display("FAIL single_byte%0d: got %02h, required %02h", b, byte_q[b], exp_b[b]);
        end
      end
      for (int b = 1; b < 6; b++) begin
        checks++;
        if (stamp_q[b] - stamp_q[b-1] != 5) begin
          errors++;
          $display("FAIL single_gap%0d: got %0d, required 5", b, stamp_q[b] - stamp_q[b-1]);
        end
      end
    end
    checks++;
    if (tx_frames !== 16'd1) begin
      errors++;
      $display("FAIL single_frames: got %0d, required 1", tx_frames);
    end
    $display("test_single: %0d bytes, frames=%0d", byte_q.size(), tx_frames);
    clear_logs();
  endtask

  task automatic test_reset_midframe();
    busy_mode = 0;
    clear_logs();
    pc_q.push_back(32'hCAFE_BABE);
    for (int i = 0; i < 100 && byte_q.size() < 2; i++) step();
    rst = 1'b1;
    step();
    checks++;
    if (uart_wr_i !== 1'b0 || uart_dat_i !== 8'h00) begin
      errors++;
      $display("FAIL midreset_uart: got wr=%b dat=%02h, required 0/00", uart_wr_i, uart_dat_i);
    end
    clear_logs();
    step();
    rst = 1'b0;
    repeat (60) step();
    checks++;
    if (byte_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_strobes: got %0d bytes after reset, required 0", byte_q.size());
    end
    checks++;
    if (fifo_count !== 4'd0 || tx_frames !== 16'd0) begin
      errors++;
      $display("FAIL midreset_counts: got count=%0d frames=%0d, required 0/0", fifo_count, tx_frames);
    end
    $display("test_reset_midframe: frames=%0d count=%0d", tx_frames, fifo_count);
    clear_logs();
  endtask

  task automatic test_both();
    logic [31:0] exp_w [6];
    logic        exp_t [6];
    exp_w[0] = 32'h1111_0001; exp_t[0] = 1'b0;
    exp_w[1] = 32'h2222_0001; exp_t[1] = 1'b1;
    exp_w[2] = 32'h1111_0002; exp_t[2] = 1'b0;
    exp_w[3] = 32'h2222_0002; exp_t[3] = 1'b1;
    exp_w[4] = 32'h1111_0003; exp_t[4] = 1'b0;
    exp_w[5] = 32'h2222_0003; exp_t[5] = 1'b1;
    busy_mode = 0;
    clear_logs();
    for (int k = 0; k < 6; k += 2) begin
      pc_q.push_back(exp_w[k]);
      v0_q.push_back(exp_w[k+1]);
    end
    for (int i = 0; i < 1500 && byte_q.size() < 36; i++) step();
    repeat (10) step();
    checks++;
    if (grant_q.size() != 6) begin
      errors++;
      $display("FAIL both_grants: got %0d grants, required 6", grant_q.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (grant_q[k] != (k % 2)) begin
          errors++;
          $display("FAIL both_grant%0d: got src %0d, required %0d", k, grant_q[k], k % 2);
        end
      end
    end
    checks++;
    if (byte_q.size() != 36) begin
      errors++;
      $display("FAIL both_count: got %0d bytes, required 36", byte_q.size());
    end else begin
      for (int f = 0; f < 6; f++) begin
        for (int b = 0; b < 6; b++) begin
          checks++;
          if (byte_q[f*6+b] !== fb(exp_t[f], exp_w[f], b)) begin
            errors++;
            $display("FAIL both_f%0d_b%0d: got %02h, required %02h", f, b,
                     byte_q[f*6+b], fb(exp_t[f], exp_w[f], b));
          end
        end
      end
    end
    checks++;
    if (tx_frames !== 16'd6) begin
      errors++;
      $display("FAIL both_frames: got %0d, required 6", tx_frames);
    end
    $display("test_both: %0d grants, %0d bytes, frames=%0d", grant_q.size(), byte_q.size(), tx_frames);
    clear_logs();
  endtask

  // The FSM pops one word into its frame register before stalling, so 10 words fill 8 slots + 1 held
  task automatic test_fill();
    busy_mode = 1;
    clear_logs();
    step();
    for (int k = 0; k < 10; k++) pc_q.push_back(32'hF000_0000 + k);
    repeat (20) step();
    checks++;
    if (fifo_count !== 4'd8) begin
      errors++;
      $display("FAIL fill_count: got %0d, required 8", fifo_count);
    end
    checks++;
    if (pc_ready !== 1'b0 || v0_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_ready: got pc=%b v0=%b, required 0/0", pc_ready, v0_ready);
    end
    checks++;
    if (pc_valid !== 1'b1 || pc_q.size() != 1 || byte_q.size() != 0) begin
      errors++;
      $display("FAIL fill_held: got valid=%b pending=%0d bytes=%0d, required 1/1/0",
               pc_valid, pc_q.size(), byte_q.size());
    end
    busy_mode = 0;
    for (int i = 0; i < 3000 && byte_q.size() < 60; i++) step();
    repeat (10) step();
    checks++;
    if (byte_q.size() != 60) begin
      errors++;
      $display("FAIL fill_bytes: got %0d bytes, required 60", byte_q.size());
    end else begin
      for (int f = 0; f < 10; f++) begin
        for (int b = 0; b < 6; b++) begin
          checks++;
          if (byte_q[f*6+b] !== fb(1'b0, 32'hF000_0000 + f, b)) begin
            errors++;
            $display("FAIL fill_f%0d_b%0d: got %02h, required %02h", f, b,
                     byte_q[f*6+b], fb(1'b0, 32'hF000_0000 + f, b));
          end
        end
      end
    end
    checks++;
    if (tx_frames !== 16'd16) begin
      errors++;
      $display("FAIL fill_frames: got %0d, required 16", tx_frames);
    end
    $display("test_fill: %0d bytes, frames=%0d", byte_q.size(), tx_frames);
    clear_logs();
  endtask

  // Pointer favours V0 after the PC-only fill, so V0 goes out first
  task automatic test_busy();
    logic [31:0] exp_w [2];
    logic        exp_t [2];
    exp_w[0] = 32'h0BAD_F00D; exp_t[0] = 1'b1;
    exp_w[1] = 32'hDEAD_BEEF; exp_t[1] = 1'b0;
    busy_mode = 2;
    clear_logs();
    pc_q.push_back(32'hDEAD_BEEF);
    v0_q.push_back(32'h0BAD_F00D);
    for (int i = 0; i < 1000 && byte_q.size() < 12; i++) step();
    repeat (20) step();
    busy_mode = 0;
    step();
    checks++;
    if (byte_q.size() != 12) begin
      errors++;
      $display("FAIL busy_count: got %0d bytes, required 12", byte_q.size());
    end else begin
      for (int f = 0; f < 2; f++) begin
        for (int b = 0; b < 6; b++) begin
          checks++;
          if (byte_q[f*6+b] !== fb(exp_t[f], exp_w[f], b)) begin
            errors++;
            $display("FAIL busy_f%0d_b%0d: got %02h, required %02h", f, b,
                     byte_q[f*6+b], fb(exp_t[f], exp_w[f], b));
          end
          if (b != 0) begin
            checks++;
            if (stamp_q[f*6+b] - stamp_q[f*6+b-1] != 13) begin
              errors++;
              $display("FAIL busy_gap_f%0d_b%0d: got %0d, required 13", f, b,
                       stamp_q[f*6+b] - stamp_q[f*6+b-1]);
            end
          end
        end
      end
    end
    checks++;
    if (tx_frames !== 16'd18) begin
      errors++;
      $display("FAIL busy_frames: got %0d, required 18", tx_frames);
    end
    $display("test_busy: %0d bytes, frames=%0d", byte_q.size(), tx_frames);
    clear_logs();
  endtask

  task automatic test_wrap();
    busy_mode = 0;
    clear_logs();
    step();
    force dut.r_frames = 16'hFFFF;
    step();
    release dut.r_frames;
    step();
    checks++;
    if (tx_frames !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_preload: got %04h, required FFFF", tx_frames);
    end
    pc_q.push_back(32'h0000_0001);
    for (int i = 0; i < 200 && byte_q.size() < 6; i++) step();
    repeat (10) step();
    checks++;
    if (byte_q.size() != 6 || tx_frames !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_frames: got %04h after %0d bytes, required 0000 after 6",
               tx_frames, byte_q.size());
    end
    $display("test_wrap: frames=%04h", tx_frames);
    clear_logs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_midframe();
    test_both();
    test_fill();
    test_busy();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
